bus_port_fifo: RTL and testbench

BUS_PORT_FIFO -- requirements
Module: bus_port_fifo

---
 rtl/bus_port_fifo.sv | 119 +++++++++++
 tb/tb_bus_port_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_port_fifo.sv
// Bus port with independent TX/RX circular FIFOs, destination-address filtering on the RX
// side, and sticky overflow/drop status that err_clr clears.
module bus_port_fifo #(
    parameter int unsigned pckg_sz    = 16,
    parameter int unsigned fifo_depth = 16,
    parameter logic [7:0]  id         = 8'd0,
    parameter logic [7:0]  broadcast  = {8{1'b1}}
) (
    input  logic               clk,
    input  logic               reset,
    // bus side
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    // device side
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    // error status
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic [7:0]         rx_drop_cnt,
    input  logic               err_clr
);
    localparam int unsigned AW = $clog2(fifo_depth);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full = CW'(fifo_depth);

    logic [pckg_sz-1:0] tx_mem [fifo_depth];
    logic [pckg_sz-1:0] rx_mem [fifo_depth];

    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic       tx_do_wr, tx_do_pop, rx_do_wr, rx_do_rd, addr_ok, rx_drop;
    logic [7:0] dest;

    always_comb begin
        dest      = D_push[pckg_sz-1 -: 8];
        addr_ok   = (dest == id) || (dest == broadcast);
        tx_do_pop = pop && (tx_cnt_q != '0);
        // A full FIFO still accepts a write when the head leaves on the same edge.
        tx_do_wr  = tx_wr && ((tx_cnt_q != Full) || tx_do_pop);
        rx_do_rd  = rx_rd && (rx_cnt_q != '0);
        rx_do_wr  = push && addr_ok && ((rx_cnt_q != Full) || rx_do_rd);
        rx_drop   = push && !rx_do_wr;
    end

    always_comb begin
        tx_wptr_d = tx_do_wr  ? tx_wptr_q + 1'b1 : tx_wptr_q;
        tx_rptr_d = tx_do_pop ? tx_rptr_q + 1'b1 : tx_rptr_q;
        tx_cnt_d  = tx_cnt_q;
        if (tx_do_wr && !tx_do_pop) tx_cnt_d = tx_cnt_q + 1'b1;
        if (!tx_do_wr && tx_do_pop) tx_cnt_d = tx_cnt_q - 1'b1;

        rx_wptr_d = rx_do_wr ? rx_wptr_q + 1'b1 : rx_wptr_q;
        rx_rptr_d = rx_do_rd ? rx_rptr_q + 1'b1 : rx_rptr_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_do_wr && !rx_do_rd) rx_cnt_d = rx_cnt_q + 1'b1;
        if (!rx_do_wr && rx_do_rd) rx_cnt_d = rx_cnt_q - 1'b1;

        // Clear first so an event on the same edge still registers.
        tx_ovf_d   = err_clr ? 1'b0 : tx_ovf_q;
        rx_ovf_d   = err_clr ? 1'b0 : rx_ovf_q;
        drop_cnt_d = err_clr ? 8'd0 : drop_cnt_q;
        if (tx_wr && !tx_do_wr) tx_ovf_d = 1'b1;
        if (push && addr_ok && !rx_do_wr) rx_ovf_d = 1'b1;
        if (rx_drop && (drop_cnt_d != 8'hFF)) drop_cnt_d = drop_cnt_d + 8'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_cnt_q   <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; the counts alone decide what is visible.
    always_ff @(posedge clk) begin
        if (tx_do_wr) tx_mem[tx_wptr_q] <= tx_data;
        if (rx_do_wr) rx_mem[rx_wptr_q] <= D_push;
    end

    always_comb begin
        pndng       = (tx_cnt_q != '0);
        tx_full     = (tx_cnt_q == Full);
        rx_valid    = (rx_cnt_q != '0);
        D_pop       = pndng ? tx_mem[tx_rptr_q] : '0;
        rx_data     = rx_valid ? rx_mem[rx_rptr_q] : '0;
        tx_ovf      = tx_ovf_q;
        rx_ovf      = rx_ovf_q;
        rx_drop_cnt = drop_cnt_q;
    end
endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed bench for bus_port_fifo (id = 2): inputs change and outputs are sampled on the
// falling edge, so each tick() spans exactly one rising edge.
module tb_bus_port_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pndng, pop = 1'b0, push = 1'b0;
    logic [15:0] D_pop, D_push = '0;
    logic        tx_wr = 1'b0, tx_full, rx_rd = 1'b0, rx_valid;
    logic [15:0] tx_data = '0, rx_data;
    logic        tx_ovf, rx_ovf, err_clr = 1'b0;
    logic [7:0]  rx_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_port_fifo #(
        .pckg_sz   (16),
        .fifo_depth(16),
        .id        (8'h02),
        .broadcast (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pndng      (pndng),
        .D_pop      (D_pop),
        .pop        (pop),
        .push       (push),
        .D_push     (D_push),
        .tx_wr      (tx_wr),
        .tx_data    (tx_data),
        .tx_full    (tx_full),
        .rx_rd      (rx_rd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_ovf     (tx_ovf),
        .rx_ovf     (rx_ovf),
        .rx_drop_cnt(rx_drop_cnt),
        .err_clr    (err_clr)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({pndng, tx_full, rx_valid, tx_ovf, rx_ovf} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {pndng, tx_full, rx_valid, tx_ovf, rx_ovf});
        end
        n_cmp++;
        if ({D_pop, rx_data, rx_drop_cnt} !== 40'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h expected 0", {D_pop, rx_data, rx_drop_cnt});
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        tx_wr = 1'b1; tx_data = 16'h0123;
        tick();
        tx_wr = 1'b0;
        n_cmp++;
        if ({pndng, D_pop} !== {1'b1, 16'h0123}) begin
            n_err++;
            $display("FAIL single_wr: got pndng=%b D_pop=%h expected 1/0123", pndng, D_pop);
        end
        pop = 1'b1;
        tick();
        n_cmp++;
        if ({pndng, D_pop} !== 17'h0) begin
            n_err++;
            $display("FAIL single_pop: got pndng=%b D_pop=%h expected 0/0000", pndng, D_pop);
        end
        // Pop on an empty FIFO must be ignored.
        tick();
        pop = 1'b0;
        n_cmp++;
        if ({pndng, tx_full} !== 2'b00) begin
            n_err++;
            $display("FAIL empty_pop: got pndng=%b full=%b expected 0/0", pndng, tx_full);
        end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 16; i++) begin
            tx_wr = 1'b1; tx_data = 16'(i);
            tick();
        end
        tx_wr = 1'b0;
        n_cmp++;
        if ({tx_full, tx_ovf} !== 2'b10) begin
            n_err++;
            $display("FAIL tx_fill: got full=%b ovf=%b expected 1/0", tx_full, tx_ovf);
        end
        tx_wr = 1'b1; tx_data = 16'hBEEF;
        tick();
        tx_wr = 1'b0;
        n_cmp++;
        if ({tx_full, tx_ovf} !== 2'b11) begin
            n_err++;
            $display("FAIL tx_ovf: got full=%b ovf=%b expected 1/1", tx_full, tx_ovf);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({pndng, D_pop} !== {1'b1, 16'(i)}) begin
                n_err++;
                $display("FAIL tx_order[%0d]: got pndng=%b D_pop=%h expected 1/%h",
                         i, pndng, D_pop, 16'(i));
            end
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        n_cmp++;
        if ({pndng, D_pop} !== 17'h0) begin
            n_err++;
            $display("FAIL tx_drain: got pndng=%b D_pop=%h expected 0/0000", pndng, D_pop);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (tx_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL tx_ovf_clr: got %b expected 0", tx_ovf);
        end
    endtask

    task automatic test_tx_wrap();
        logic [15:0] exp_q [$];
        // Offset the pointers so the full window straddles the wrap point.
        for (int i = 0; i < 3; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0AAA;
            tick();
            tx_wr = 1'b0; pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0100 + 16'(i);
            tick();
        end
        for (int i = 4; i < 16; i++) exp_q.push_back(16'h0100 + 16'(i));
        for (int i = 0; i < 4; i++) begin
            tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h0200 + 16'(i);
            tick();
            exp_q.push_back(16'h0200 + 16'(i));
        end
        tx_wr = 1'b0; pop = 1'b0;
        n_cmp++;
        if ({tx_full, tx_ovf, D_pop} !== {2'b10, 16'h0104}) begin
            n_err++;
            $display("FAIL wr_pop_full: got full=%b ovf=%b D_pop=%h expected 1/0/0104",
                     tx_full, tx_ovf, D_pop);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (D_pop !== exp_q[i]) begin
                n_err++;
                $display("FAIL wrap_order[%0d]: got %h expected %h", i, D_pop, exp_q[i]);
            end
            pop = 1'b1;
            tick();
        end
        pop = 1'b0;
        // Write and pop together on an empty FIFO: enqueue only.
        tx_wr = 1'b1; pop = 1'b1; tx_data = 16'h5A5A;
        tick();
        tx_wr = 1'b0; pop = 1'b0;
        n_cmp++;
        if ({pndng, D_pop} !== {1'b1, 16'h5A5A}) begin
            n_err++;
            $display("FAIL wr_pop_empty: got pndng=%b D_pop=%h expected 1/5a5a", pndng, D_pop);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_rx_addr();
        logic [15:0] pk [3] = '{16'h02AA, 16'hFF55, 16'h0711};
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; D_push = pk[i];
            tick();
        end
        push = 1'b0;
        n_cmp++;
        if ({rx_valid, rx_data, rx_drop_cnt} !== {1'b1, 16'h02AA, 8'd1}) begin
            n_err++;
            $display("FAIL rx_filter: got valid=%b data=%h drop=%0d expected 1/02aa/1",
                     rx_valid, rx_data, rx_drop_cnt);
        end
        rx_rd = 1'b1;
        tick();
        n_cmp++;
        if (rx_data !== 16'hFF55) begin
            n_err++;
            $display("FAIL rx_bcast: got %h expected ff55", rx_data);
        end
        tick();
        tick();
        rx_rd = 1'b0;
        n_cmp++;
        if ({rx_valid, rx_data, rx_drop_cnt} !== {1'b0, 16'h0, 8'd1}) begin
            n_err++;
            $display("FAIL rx_empty_rd: got valid=%b data=%h drop=%0d expected 0/0000/1",
                     rx_valid, rx_data, rx_drop_cnt);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_rx_ovf();
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; D_push = 16'h0200 + 16'(i);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            push = 1'b1; D_push = 16'hFF00 + 16'(i % 256);
            tick();
        end
        push = 1'b0;
        n_cmp++;
        if ({rx_ovf, rx_drop_cnt, rx_data} !== {1'b1, 8'd255, 16'h0200}) begin
            n_err++;
            $display("FAIL rx_sat: got ovf=%b drop=%0d data=%h expected 1/255/0200",
                     rx_ovf, rx_drop_cnt, rx_data);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if ({rx_ovf, rx_drop_cnt} !== 9'h0) begin
            n_err++;
            $display("FAIL rx_clr: got ovf=%b drop=%0d expected 0/0", rx_ovf, rx_drop_cnt);
        end
        // Drop on the same edge as err_clr wins.
        err_clr = 1'b1; push = 1'b1; D_push = 16'h0299;
        tick();
        err_clr = 1'b0; push = 1'b0;
        n_cmp++;
        if ({rx_ovf, rx_drop_cnt} !== {1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL clr_vs_drop: got ovf=%b drop=%0d expected 1/1", rx_ovf, rx_drop_cnt);
        end
        // Full RX with a read on the same edge accepts the push.
        push = 1'b1; rx_rd = 1'b1; D_push = 16'h02CC;
        tick();
        push = 1'b0;
        n_cmp++;
        if ({rx_valid, rx_data, rx_drop_cnt} !== {1'b1, 16'h0201, 8'd1}) begin
            n_err++;
            $display("FAIL rx_rd_push_full: got valid=%b data=%h drop=%0d expected 1/0201/1",
                     rx_valid, rx_data, rx_drop_cnt);
        end
        for (int i = 1; i < 16; i++) tick();
        n_cmp++;
        if ({rx_valid, rx_data} !== {1'b1, 16'h02CC}) begin
            n_err++;
            $display("FAIL rx_last: got valid=%b data=%h expected 1/02cc", rx_valid, rx_data);
        end
        tick();
        rx_rd = 1'b0;
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_drained: got %b expected 0", rx_valid);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) begin
            tx_wr = 1'b1; tx_data = 16'h0C00 + 16'(i);
            tick();
        end
        n_cmp++;
        if ({pndng, D_pop} !== {1'b1, 16'h0C00}) begin
            n_err++;
            $display("FAIL burst: got pndng=%b D_pop=%h expected 1/0c00", pndng, D_pop);
        end
        // tx_wr stays high: writes while reset is low must be ignored.
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({pndng, D_pop} !== 17'h0) begin
            n_err++;
            $display("FAIL async_rst: got pndng=%b D_pop=%h expected 0/0000", pndng, D_pop);
        end
        tick();
        tick();
        tx_wr = 1'b0;
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({pndng, tx_full, D_pop} !== 18'h0) begin
            n_err++;
            $display("FAIL post_rst: got pndng=%b full=%b D_pop=%h expected 0/0/0000",
                     pndng, tx_full, D_pop);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        n_cmp++;
        if ({pndng, D_pop} !== 17'h0) begin
            n_err++;
            $display("FAIL stale_pop: got pndng=%b D_pop=%h expected 0/0000", pndng, D_pop);
        end
        tx_wr = 1'b1; tx_data = 16'h0D0D;
        tick();
        tx_wr = 1'b0;
        n_cmp++;
        if ({pndng, D_pop} !== {1'b1, 16'h0D0D}) begin
            n_err++;
            $display("FAIL after_rst_wr: got pndng=%b D_pop=%h expected 1/0d0d", pndng, D_pop);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_single();
        test_tx_full();
        test_tx_wrap();
        test_rx_addr();
        test_rx_ovf();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
